wb_write_queue: RTL and testbench

//  Write-side producer for the register file write port (Dest_wb/Result_wb/writeBackEn).

---
 rtl/wb_write_queue.sv | 157 +++++++++++++++
 tb/tb_wb_write_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order write-back queue feeding the register file port.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   mem_valid/ready/dest/data  memory-path result handshake (priority)
//   alu_valid/ready/dest/data  ALU-path result handshake
//   wb_stall                   hold the write port this cycle
//   writeBackEn/Dest_wb/Result_wb  registered register-file write port
//   src1/src2 -> hit1/2, fwd1/2    pending-write lookup for ID
//   count                      entries held in the queue
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_dest,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_dest,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       wb_stall,
  output logic                       writeBackEn,
  output logic [ADDR_W-1:0]          Dest_wb,
  output logic [DATA_W-1:0]          Result_wb,
  input  logic [ADDR_W-1:0]          src1,
  input  logic [ADDR_W-1:0]          src2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DATA_W-1:0]          fwd1,
  output logic [DATA_W-1:0]          fwd2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_W-1:0] dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wdest_q, wdest_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              full, empty;
  logic              push, pop;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // MEM is the older instruction, so ALU waits whenever MEM offers.
  // A full queue refuses even while draining: no pass-through.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign push    = (mem_valid && mem_ready) ||
                   (alu_valid && alu_ready);
  assign in_dest = mem_valid ? mem_dest : alu_dest;
  assign in_data = mem_valid ? mem_data : alu_data;

  assign pop = !wb_stall && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we_d    = we_q;
    wdest_d = wdest_q;
    wdata_d = wdata_q;

    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A stalled port keeps re-presenting the same write.
    if (!wb_stall) begin
      we_d = !empty;
      if (!empty) begin
        wdest_d = dest_q[head_q];
        wdata_d = data_q[head_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wdest_q <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdest_q <= wdest_d;
      wdata_q <= wdata_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[tail_q] <= in_dest;
      data_q[tail_q] <= in_data;
    end
  end

  // Search oldest to youngest so the youngest match overrides;
  // the output register is older than every queued entry.
  function automatic logic [DATA_W:0] find(
    input logic [ADDR_W-1:0] src
  );
    logic              h;
    logic [DATA_W-1:0] f;
    logic [PW-1:0]     idx;
    h = 1'b0;
    f = '0;
    if (we_q && (wdest_q == src)) begin
      h = 1'b1;
      f = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (dest_q[idx] == src)) begin
        h = 1'b1;
        f = data_q[idx];
      end
    end
    return {h, f};
  endfunction

  always_comb {hit1, fwd1} = find(src1);
  always_comb {hit2, fwd2} = find(src2);

  assign writeBackEn = we_q;
  assign Dest_wb     = wdest_q;
  assign Result_wb   = wdata_q;
  assign count       = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Testbench for wb_write_queue: directed vector table, hand sequences
// and a randomized run checked against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        wb_stall;
  logic        writeBackEn;
  logic [4:0]  Dest_wb;
  logic [31:0] Result_wb;
  logic [4:0]  src1, src2;
  logic        hit1, hit2;
  logic [31:0] fwd1, fwd2;
  logic [2:0]  count;

  wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dest(mem_dest), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_dest(alu_dest), .alu_data(alu_data),
    .wb_stall(wb_stall),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb),
    .Result_wb(Result_wb),
    .src1(src1), .src2(src2),
    .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_dest = '0;
  logic [31:0] m_data = '0;
  logic [31:0] exp_rf [32];
  logic [31:0] dut_rf [32];
  bit          chk_on = 0;

  function automatic void model_look(input logic [4:0] s,
                                     output logic h,
                                     output logic [31:0] f);
    h = 1'b0;
    f = '0;
    if (m_we && m_dest == s) begin
      h = 1'b1;
      f = m_data;
    end
    foreach (sb[i]) begin
      if (sb[i].dest == s) begin
        h = 1'b1;
        f = sb[i].data;
      end
    end
  endfunction

  // Reference model: update on each edge, then check registered outputs.
  always begin : model
    logic st, rs, mfull;
    ent_t e;
    @(posedge clk);
    st = wb_stall;
    rs = rst;
    if (rst) begin
      sb.delete();
      m_we   = 1'b0;
      m_dest = '0;
      m_data = '0;
    end else begin
      mfull = (sb.size() == DEPTH);
      if (!wb_stall) begin
        if (sb.size() > 0) begin
          e      = sb.pop_front();
          m_we   = 1'b1;
          m_dest = e.dest;
          m_data = e.data;
        end else begin
          m_we = 1'b0;
        end
      end
      if (mem_valid && !mfull) begin
        sb.push_back('{mem_dest, mem_data});
        exp_rf[mem_dest] = mem_data;
      end else if (alu_valid && !mfull && !mem_valid) begin
        sb.push_back('{alu_dest, alu_data});
        exp_rf[alu_dest] = alu_data;
      end
    end
    #1;
    if (chk_on) begin
      chk("m_we", writeBackEn, m_we);
      if (m_we) begin
        chk("m_dest", Dest_wb, m_dest);
        chk("m_data", Result_wb, m_data);
      end
      chk("m_count", count, sb.size());
    end
    if (!rs && !st && writeBackEn === 1'b1)
      dut_rf[Dest_wb] = Result_wb;
  end

  always @(negedge clk) begin : comb_chk
    logic mfull, h;
    logic [31:0] f;
    if (chk_on) begin
      mfull = (sb.size() == DEPTH);
      chk("m_mem_ready", mem_ready, !mfull);
      chk("m_alu_ready", alu_ready, !mfull && !mem_valid);
      model_look(src1, h, f);
      chk("m_hit1", hit1, h);
      chk("m_fwd1", fwd1, f);
      model_look(src2, h, f);
      chk("m_hit2", hit2, h);
      chk("m_fwd2", fwd2, f);
    end
  end

  typedef struct {
    logic        rst, mv;
    logic [4:0]  md;
    logic [31:0] mdat;
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adat;
    logic        st;
    logic [4:0]  s1, s2;
    logic        mr, ar, h1;
    logic [31:0] f1;
    logic        h2;
    logic [31:0] f2;
    logic        we;
    logic [4:0]  d;
    logic [31:0] r;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; alu_valid = 0; wb_stall = 0;
    mem_dest = '0; mem_data = '0;
    alu_dest = '0; alu_data = '0;
    src1 = '0; src2 = '0;
  endtask

  initial begin
    bit acc;
    // rst mv md mdat av ad adat st s1 s2 | mr ar h1 f1 h2 f2 | we d r cnt
    tbl[0]  = '{0,1,3,'hA5,0,0,0,0,0,0, 1,0,0,0,0,0, 0,0,0,1};
    tbl[1]  = '{0,0,0,0,0,0,0,0,3,0, 1,1,1,'hA5,0,0, 1,3,'hA5,0};
    tbl[2]  = '{0,0,0,0,0,0,0,0,3,0, 1,1,1,'hA5,0,0, 0,0,0,0};
    tbl[3]  = '{0,0,0,0,0,0,0,0,3,0, 1,1,0,0,0,0, 0,0,0,0};
    tbl[4]  = '{0,1,2,'h22,1,5,'h55,0,0,0, 1,0,0,0,0,0, 0,0,0,1};
    tbl[5]  = '{0,0,0,0,1,5,'h55,0,2,5, 1,1,1,'h22,0,0, 1,2,'h22,1};
    tbl[6]  = '{0,0,0,0,0,0,0,0,2,5, 1,1,1,'h22,1,'h55, 1,5,'h55,0};
    tbl[7]  = '{0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0,0, 0,0,0,0};
    tbl[8]  = '{0,1,7,'h11,0,0,0,1,0,0, 1,0,0,0,0,0, 0,0,0,1};
    tbl[9]  = '{0,0,0,0,1,7,'h22,1,7,9, 1,1,1,'h11,0,0, 0,0,0,2};
    tbl[10] = '{0,0,0,0,0,0,0,1,7,9, 1,1,1,'h22,0,0, 0,0,0,2};
    tbl[11] = '{0,0,0,0,0,0,0,0,7,9, 1,1,1,'h22,0,0, 1,7,'h11,1};
    tbl[12] = '{0,0,0,0,0,0,0,0,7,9, 1,1,1,'h22,0,0, 1,7,'h22,0};
    tbl[13] = '{0,0,0,0,0,0,0,0,7,9, 1,1,1,'h22,0,0, 0,0,0,0};
    tbl[14] = '{0,1,1,'h101,0,0,0,1,0,0, 1,0,0,0,0,0, 0,0,0,1};
    tbl[15] = '{0,1,2,'h102,0,0,0,1,0,0, 1,0,0,0,0,0, 0,0,0,2};
    tbl[16] = '{0,1,3,'h103,0,0,0,1,0,0, 1,0,0,0,0,0, 0,0,0,3};
    tbl[17] = '{1,0,0,0,0,0,0,0,1,3, 1,1,1,'h101,1,'h103, 0,0,0,0};
    tbl[18] = '{0,0,0,0,0,0,0,0,1,3, 1,1,0,0,0,0, 0,0,0,0};
    tbl[19] = '{0,0,0,0,0,0,0,0,1,3, 1,1,0,0,0,0, 0,0,0,0};

    idle();
    rst = 1;
    step();
    step();
    chk("rst_we", writeBackEn, 0);
    chk("rst_dest", Dest_wb, 0);
    chk("rst_data", Result_wb, 0);
    chk("rst_count", count, 0);
    rst = 0;
    chk_on = 1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      mem_valid = tbl[i].mv;
      mem_dest = tbl[i].md;
      mem_data = tbl[i].mdat;
      alu_valid = tbl[i].av;
      alu_dest = tbl[i].ad;
      alu_data = tbl[i].adat;
      wb_stall = tbl[i].st;
      src1 = tbl[i].s1;
      src2 = tbl[i].s2;
      @(negedge clk);
      chk($sformatf("v%0d_mem_ready", i), mem_ready, tbl[i].mr);
      chk($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].ar);
      chk($sformatf("v%0d_hit1", i), hit1, tbl[i].h1);
      chk($sformatf("v%0d_fwd1", i), fwd1, tbl[i].f1);
      chk($sformatf("v%0d_hit2", i), hit2, tbl[i].h2);
      chk($sformatf("v%0d_fwd2", i), fwd2, tbl[i].f2);
      step();
      chk($sformatf("v%0d_we", i), writeBackEn, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("v%0d_dest", i), Dest_wb, tbl[i].d);
        chk($sformatf("v%0d_data", i), Result_wb, tbl[i].r);
      end
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
    end
    rst = 0;
    idle();

    // Fill under stall, hold a fifth entry, then drain across the wrap.
    wb_stall = 1;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1;
      mem_dest = 5'(10 + i);
      mem_data = 32'h300 + i;
      step();
    end
    mem_dest = 5'd14;
    mem_data = 32'h304;
    alu_valid = 1;
    alu_dest = 5'd15;
    alu_data = 32'h305;
    @(negedge clk);
    chk("full_count", count, 4);
    chk("full_mem_ready", mem_ready, 0);
    chk("full_alu_ready", alu_ready, 0);
    step();
    alu_valid = 0;
    @(negedge clk);
    chk("full_hold_count", count, 4);
    step();
    wb_stall = 0;
    @(negedge clk);
    chk("full_drain_ready", mem_ready, 0);
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        acc = 1;
        step();
        break;
      end
      step();
    end
    chk("fifth_accepted", acc, 1);
    idle();
    repeat (8) step();
    chk("full_drained", count, 0);

    // Randomized traffic against the model.
    foreach (exp_rf[i]) begin
      exp_rf[i] = '0;
      dut_rf[i] = '0;
    end
    for (int c = 0; c < 2000; c++) begin
      mem_valid = ($urandom_range(0, 99) < 40);
      alu_valid = ($urandom_range(0, 99) < 50);
      wb_stall  = ($urandom_range(0, 99) < 25);
      mem_dest  = 5'($urandom);
      mem_data  = $urandom;
      alu_dest  = 5'($urandom);
      alu_data  = $urandom;
      src1      = 5'($urandom);
      src2      = 5'($urandom);
      step();
    end
    idle();
    repeat (10) step();
    chk("rand_count_empty", count, 0);
    foreach (exp_rf[i])
      chk($sformatf("rf_r%0d", i), dut_rf[i], exp_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
